// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per completion unit,
// round-robin selection into a registered CDB broadcast stage with flush and conflict counting.
module cdb_arbiter #(
  parameter type T         = logic [31:0],
  parameter int  NUM_REQ   = 3,
  parameter int  ROB_TAG_W = 5,
  parameter int  PREG_W    = 7,
  parameter int  CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ROB_TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*PREG_W-1:0]     req_prd,
  input  logic [NUM_REQ*$bits(T)-1:0]   req_data,
  output logic                          cdb_valid,
  output logic [ROB_TAG_W-1:0]          cdb_tag,
  output logic [PREG_W-1:0]             cdb_prd,
  output logic [$bits(T)-1:0]           cdb_data,
  output logic [$clog2(NUM_REQ)-1:0]    cdb_src,
  output logic [CNT_W-1:0]              conflict_cnt
);

  localparam int            DW   = $bits(T);
  localparam int            SW   = $clog2(NUM_REQ);
  localparam logic [SW-1:0] LAST = SW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]   hold_valid_q, hold_valid_d;
  logic [ROB_TAG_W-1:0] hold_tag_q  [NUM_REQ];
  logic [ROB_TAG_W-1:0] hold_tag_d  [NUM_REQ];
  logic [PREG_W-1:0]    hold_prd_q  [NUM_REQ];
  logic [PREG_W-1:0]    hold_prd_d  [NUM_REQ];
  logic [DW-1:0]        hold_data_q [NUM_REQ];
  logic [DW-1:0]        hold_data_d [NUM_REQ];

  logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [PREG_W-1:0]    cdb_prd_q, cdb_prd_d;
  logic [DW-1:0]        cdb_data_q, cdb_data_d;
  logic [SW-1:0]        cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]     conflict_q, conflict_d;

  logic [NUM_REQ-1:0]   grant;
  logic                 win_found;
  logic [SW-1:0]        win_idx;
  int                   scan_idx;

  // Round-robin scan starting at rr_ptr; the first held result found wins.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
    grant     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && hold_valid_q[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = SW'(scan_idx);
      end
    end
    if (win_found) grant[win_idx] = 1'b1;
  end

  // Ready depends only on held state, grant, rst and flush: never on req_valid.
  always_comb begin
    req_ready = '0;
    if (!rst && !flush) req_ready = ~hold_valid_q | grant;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_prd_d   = hold_prd_q;
    hold_data_d  = hold_data_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = cdb_tag_q;
    cdb_prd_d    = cdb_prd_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    conflict_d   = conflict_q;

    if (flush) begin
      hold_valid_d = '0;
    end else begin
      if (win_found) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = hold_tag_q[win_idx];
        cdb_prd_d   = hold_prd_q[win_idx];
        cdb_data_d  = hold_data_q[win_idx];
        cdb_src_d   = win_idx;
        rr_ptr_d    = (win_idx == LAST) ? '0 : win_idx + 1'b1;
      end

      // A granted slot may be refilled on the same edge it drains.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_tag_d[i]   = req_tag[i*ROB_TAG_W +: ROB_TAG_W];
          hold_prd_d[i]   = req_prd[i*PREG_W +: PREG_W];
          hold_data_d[i]  = req_data[i*DW +: DW];
        end else if (grant[i]) begin
          hold_valid_d[i] = 1'b0;
        end
      end

      if ($countones(hold_valid_q) > 1 && conflict_q != {CNT_W{1'b1}})
        conflict_d = conflict_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_prd_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
      conflict_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_prd_q    <= cdb_prd_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
      conflict_q   <= conflict_d;
    end
  end

  // NOTE: hold payload is left unreset; it is never observed unless its hold_valid bit is set.
  always_ff @(posedge clk) begin
    hold_tag_q  <= hold_tag_d;
    hold_prd_q  <= hold_prd_d;
    hold_data_q <= hold_data_d;
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_prd      = cdb_prd_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_q;

endmodule
